// File: rtl/jpeg_uart_packer.sv
// Buffers 16-bit encoder words and paces them into a UART one byte at a time, MSB first.
// Optional frame trailer (0xA5, 0x5A) after each tlast word when JPEG_UART_TRAILER_EN is defined.
module jpeg_uart_packer #(
    parameter int FIFO_DEPTH  = 64,
    parameter int COUNT_WIDTH = 24
) (
    input  logic                          s00_axis_aclk,
    input  logic                          s00_axis_aresetn,
    input  logic                          s00_axis_tvalid,
    output logic                          s00_axis_tready,
    input  logic [15:0]                   s00_axis_tdata,
    input  logic                          s00_axis_tlast,
    output logic [7:0]                    tx_byte_out,
    output logic                          tx_trigger_out,
    input  logic                          tx_busy_in,
    output logic                          frame_done_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
    output logic [COUNT_WIDTH-1:0]        byte_count_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FIRE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t state, state_next;

    logic              run;
    logic [16:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              wr_en;
    logic              rd_en;

    logic [7:0]        hold_hi;
    logic [7:0]        hold_lo;
    logic              hold_last;
    logic [1:0]        byte_idx;
    logic [7:0]        byte_sel;
    logic              more_bytes;
    logic              frame_end;
    logic              step;
    logic              done_pulse;

    // Reset release is registered so tready rises on the first clock after deassertion.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) run <= 1'b0;
        else                   run <= 1'b1;
    end

    assign s00_axis_tready = run && (count < FULL_LEVEL);
    assign wr_en           = s00_axis_tvalid && s00_axis_tready;
    assign rd_en           = (state == IDLE) && (count != '0);
    assign fifo_count_out  = count;

    always_ff @(posedge s00_axis_aclk) begin
        if (wr_en) mem[wr_ptr] <= {s00_axis_tlast, s00_axis_tdata};
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // byte_idx walks hi, lo and (when enabled) the two trailer bytes of the held word.
`ifdef JPEG_UART_TRAILER_EN
    assign more_bytes = (byte_idx == 2'd0) || ((byte_idx == 2'd1) && hold_last) || (byte_idx == 2'd2);
    assign frame_end  = (byte_idx == 2'd3);
`else
    assign more_bytes = (byte_idx == 2'd0);
    assign frame_end  = (byte_idx == 2'd1) && hold_last;
`endif

    always_comb begin
        byte_sel = hold_lo;
        case (byte_idx)
            2'd0:    byte_sel = hold_hi;
            2'd1:    byte_sel = hold_lo;
`ifdef JPEG_UART_TRAILER_EN
            2'd2:    byte_sel = 8'hA5;
            2'd3:    byte_sel = 8'h5A;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) state <= IDLE;
        else                   state <= state_next;
    end

    always_comb begin
        state_next     = state;
        tx_trigger_out = 1'b0;
        step           = 1'b0;
        done_pulse     = 1'b0;
        case (state)
            IDLE:      if (count != '0) state_next = LOAD;
            LOAD:      state_next = FIRE;
            FIRE: begin
                tx_trigger_out = 1'b1;
                state_next     = WAIT_ACK;
            end
            WAIT_ACK:  if (tx_busy_in) state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (!tx_busy_in) begin
                    step = 1'b1;
                    if (more_bytes) begin
                        state_next = LOAD;
                    end else begin
                        state_next = IDLE;
                        done_pulse = frame_end;
                    end
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            hold_hi        <= '0;
            hold_lo        <= '0;
            hold_last      <= 1'b0;
            byte_idx       <= '0;
            tx_byte_out    <= '0;
            byte_count_out <= '0;
            frame_done_out <= 1'b0;
        end else begin
            frame_done_out <= done_pulse;
            if (rd_en) begin
                {hold_last, hold_hi, hold_lo} <= mem[rd_ptr];
                byte_idx <= '0;
            end
            if (step && more_bytes) byte_idx <= byte_idx + 1'b1;
            if (state == LOAD) tx_byte_out <= byte_sel;
            if (state == FIRE) byte_count_out <= byte_count_out + 1'b1;
        end
    end

endmodule

// File: tb/tb_jpeg_uart_packer.sv
// Randomized bench for jpeg_uart_packer: a queue-based byte/frame model plus a simple UART busy model.
`timescale 1ns/1ps
module tb_jpeg_uart_packer;

    localparam int DEPTH = 64;
    localparam int CW    = 4;
`ifdef JPEG_UART_TRAILER_EN
    localparam bit TRL = 1'b1;
`else
    localparam bit TRL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tvalid = 1'b0;
    logic              tlast = 1'b0;
    logic [15:0]       tdata = '0;
    logic              tready;
    logic [7:0]        tx_byte;
    logic              trigger;
    logic              tx_busy;
    logic              frame_done;
    logic [6:0]        fifo_count;
    logic [CW-1:0]     byte_count;

    logic              mbusy = 1'b0;
    logic              hold = 1'b0;
    assign tx_busy = mbusy | hold;

    always #5 clk = ~clk;

    jpeg_uart_packer #(.FIFO_DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis_tvalid  (tvalid),
        .s00_axis_tready  (tready),
        .s00_axis_tdata   (tdata),
        .s00_axis_tlast   (tlast),
        .tx_byte_out      (tx_byte),
        .tx_trigger_out   (trigger),
        .tx_busy_in       (tx_busy),
        .frame_done_out   (frame_done),
        .fifo_count_out   (fifo_count),
        .byte_count_out   (byte_count)
    );

    typedef struct packed {
        logic [7:0] b;
        logic       eof;
    } ent_t;

    ent_t        expq[$];
    logic [7:0]  rx_log[$];
    ent_t        cur;
    int          total = 0;
    int          bad = 0;
    int          n_trig = 0;
    int          n_done = 0;
    int          n_acc = 0;
    bit          pending = 1'b0;
    bit          armed = 1'b0;
    bit          active = 1'b0;
    int          dcnt = 0;
    int          lcnt = 0;
    int          dly_mode = 0;
    int          len_mode = 0;
    bit          burst_done = 1'b0;
    logic [15:0] burst [70];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) t=%0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic void model_accept(input logic [15:0] d, input logic l);
        ent_t e;
        e.b = d[15:8]; e.eof = 1'b0;          expq.push_back(e);
        e.b = d[7:0];  e.eof = l && !TRL;     expq.push_back(e);
        if (TRL && l) begin
            e.b = 8'hA5; e.eof = 1'b0; expq.push_back(e);
            e.b = 8'h5A; e.eof = 1'b1; expq.push_back(e);
        end
        n_acc++;
    endfunction

    // Compare process plus UART busy model, both evaluated on the falling edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("tready_vs_level", int'(tready), int'(fifo_count < 7'(DEPTH)));
            chk("level_bound", int'(fifo_count <= 7'(DEPTH)), 1);
            chk("byte_count", int'(byte_count), n_trig % (1 << CW));
            if (frame_done) begin
                chk("frame_done_expected", int'(pending), 1);
                pending = 1'b0;
                n_done++;
            end
            if (trigger) begin
                chk("trigger_while_uart_active", int'(active), 0);
                chk("trigger_before_frame_done", int'(pending), 0);
                chk("byte_available", int'(expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    cur = expq.pop_front();
                    chk("byte_value", int'(tx_byte), int'(cur.b));
                    if (cur.eof) pending = 1'b1;
                end
                rx_log.push_back(tx_byte);
                n_trig++;
            end
        end
        if (trigger) begin
            active = 1'b1;
            dcnt = (dly_mode == 0) ? 0 : (dly_mode == 1) ? 3 : int'($urandom_range(0, 3));
            lcnt = (len_mode == 0) ? 10 : int'($urandom_range(1, 12));
        end else if (active) begin
            if (dcnt > 0)      dcnt--;
            else if (lcnt > 0) lcnt--;
            else               active = 1'b0;
        end
        mbusy = active && (dcnt == 0) && (lcnt > 0);
    end

    task automatic send_word(input logic [15:0] d, input logic l, input int gap);
        int guard;
        bit ok;
        guard = 0;
        ok = 1'b0;
        repeat (gap) @(negedge clk);
        tvalid = 1'b1; tdata = d; tlast = l;
        while (!ok) begin
            #1;
            if (tready) begin
                model_accept(d, l);
                ok = 1'b1;
            end
            @(negedge clk);
            guard++;
            if (!ok && guard > 5000) begin
                chk("send_timeout", 0, 1);
                ok = 1'b1;
            end
        end
        tvalid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!(expq.size() == 0 && !active && !pending && fifo_count == 0 && !tvalid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_budget", int'(n < budget), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_level(input int lvl, input int budget);
        int n;
        n = 0;
        while (int'(fifo_count) != lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("level_reached", int'(fifo_count), lvl);
    endtask

    task automatic check_log(input string name, input logic [7:0] exp[$]);
        chk({name, "_len"}, rx_log.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < rx_log.size()) chk(name, int'(rx_log[i]), int'(exp[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tready"},     int'(tready), 0);
        chk({tag, "_tx_byte"},    int'(tx_byte), 0);
        chk({tag, "_trigger"},    int'(trigger), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_fifo_count"}, int'(fifo_count), 0);
        chk({tag, "_byte_count"}, int'(byte_count), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] expb[$];
        int base, nb, frames, d0;
        logic [15:0] w;
        logic l;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        #1 chk("tready_before_first_edge", int'(tready), 0);
        @(negedge clk);
        chk("tready_first_cycle", int'(tready), 1);
        armed = 1'b1;

        // Single word, no tlast.
        dly_mode = 0; len_mode = 0;
        rx_log.delete(); d0 = n_done;
        send_word(16'hBEEF, 1'b0, 0);
        drain(400);
        expb = '{8'hBE, 8'hEF};
        check_log("beef_bytes", expb);
        chk("beef_triggers", n_trig, 2);
        chk("beef_byte_count", int'(byte_count), 2);
        chk("beef_no_frame_done", n_done - d0, 0);

        // Frame-ending word.
        rx_log.delete(); d0 = n_done;
        send_word(16'h1234, 1'b1, 0);
        drain(400);
        expb = '{8'h12, 8'h34};
        if (TRL) begin
            expb.push_back(8'hA5);
            expb.push_back(8'h5A);
        end
        check_log("frame_bytes", expb);
        chk("frame_done_count", n_done - d0, 1);
        chk("frame_byte_count", int'(byte_count), (2 + expb.size()) % (1 << CW));

        // Burst of 70 words against a stalled UART.
        rx_log.delete();
        hold = 1'b1;
        base = n_acc;
        for (int i = 0; i < 70; i++) burst[i] = 16'($urandom);
        burst_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 70; i++) send_word(burst[i], 1'b0, 0);
                burst_done = 1'b1;
            end
        join_none
        wait_level(DEPTH, 400);
        #1;
        chk("full_tready_low", int'(tready), 0);
        chk("full_accepted", n_acc - base, 65);
        @(negedge clk);
        hold = 1'b0;
        for (int n = 0; n < 6000 && !burst_done; n++) @(negedge clk);
        chk("burst_sent", int'(burst_done), 1);
        drain(6000);
        expb.delete();
        for (int i = 0; i < 70; i++) begin
            expb.push_back(burst[i][15:8]);
            expb.push_back(burst[i][7:0]);
        end
        check_log("burst_order", expb);

        // Busy arriving 0 cycles versus 3 cycles after the trigger.
        for (int mode = 0; mode < 2; mode++) begin
            dly_mode = mode; len_mode = 1;
            base = n_trig; nb = 0;
            for (int i = 0; i < 6; i++) begin
                w = 16'($urandom);
                l = 1'($urandom);
                nb += 2 + ((l && TRL) ? 2 : 0);
                send_word(w, l, int'($urandom_range(0, 2)));
            end
            drain(2000);
            chk("one_trigger_per_byte", n_trig - base, nb);
        end

        // Random traffic with random ack latency and gaps.
        dly_mode = 2; len_mode = 1;
        d0 = n_done; frames = 0;
        for (int i = 0; i < 30; i++) begin
            w = 16'($urandom);
            l = ($urandom_range(0, 3) == 0);
            if (l) frames++;
            send_word(w, l, int'($urandom_range(0, 5)));
        end
        drain(4000);
        chk("random_frames", n_done - d0, frames);

        // Reset while the FSM waits on busy with five words queued.
        dly_mode = 0; len_mode = 0;
        hold = 1'b1;
        for (int i = 0; i < 6; i++) send_word(16'($urandom), 1'b0, 0);
        wait_level(5, 200);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        armed = 1'b0;
        #1 check_reset_outputs("midreset");
        expq.delete();
        pending = 1'b0;
        n_trig = 0;
        hold = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("tready_after_reset_pre_edge", int'(tready), 0);
        @(negedge clk);
        chk("tready_after_reset", int'(tready), 1);
        armed = 1'b1;
        for (int n = 0; n < 100 && active; n++) @(negedge clk);
        chk("uart_idle_after_reset", int'(active), 0);

        // Counter wrap: 18 bytes with a 4-bit counter.
        rx_log.delete();
        for (int i = 0; i < 9; i++) send_word(16'($urandom), 1'b0, 0);
        drain(3000);
        chk("wrap_count", int'(byte_count), 2);
        chk("wrap_bytes", rx_log.size(), 18);

        // Normal transfer after the mid-operation reset.
        rx_log.delete(); d0 = n_done;
        send_word(16'hCAFE, 1'b1, 0);
        drain(400);
        expb = '{8'hCA, 8'hFE};
        if (TRL) begin
            expb.push_back(8'hA5);
            expb.push_back(8'h5A);
        end
        check_log("post_reset_bytes", expb);
        chk("post_reset_frame_done", n_done - d0, 1);
        chk("model_empty", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
